// File: rtl/start_done_caller_if.sv
// Bundles the three channels of start_done_caller into one interface.
//   req_*  : operand pair request, valid/ready, consumer is the caller
//   resp_* : result/timeout response, valid/ready, producer is the caller
//   call_* : start/done call to the attached callee
// master : the caller side (start_done_caller itself)
// slave  : the environment side (requester, response consumer, callee)
interface start_done_caller_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_timeout;

    logic             call_start;
    logic [WIDTH-1:0] call_a;
    logic [WIDTH-1:0] call_b;
    logic [WIDTH-1:0] call_result;
    logic             call_done;

    modport master (
        input  req_valid, req_a, req_b, resp_ready, call_result, call_done,
        output req_ready, resp_valid, resp_result, resp_timeout,
               call_start, call_a, call_b
    );

    modport slave (
        output req_valid, req_a, req_b, resp_ready, call_result, call_done,
        input  req_ready, resp_valid, resp_result, resp_timeout,
               call_start, call_a, call_b
    );
endinterface

// File: rtl/start_done_caller.sv
// Hardware initiator for start/done callees. Takes operand pairs from the
// request channel, issues one call at a time, waits for done (or gives up
// after TIMEOUT wait cycles) and queues the outcome in a small response FIFO.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   bus           start_done_caller_if.master (req, resp and call channels)
//   busy          high whenever the FSM is not idle
//   timeout_count saturating count of abandoned calls
//
// state | meaning
// IDLE  | ready for a request while a FIFO slot is free
// ISSUE | call_start pulse, operands already registered
// GUARD | ignore call_done (may be stale from the previous call)
// WAIT  | sample call_done, count toward timeout
module start_done_caller #(
    parameter int WIDTH      = 32,
    parameter int TIMEOUT    = 64,
    parameter int RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    start_done_caller_if.master bus,
    output logic                busy,
    output logic [7:0]          timeout_count
);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GUARD, ST_WAIT} state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic [WIDTH:0]    mem [RESP_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              accept;
    logic              push;
    logic              pop;
    logic [WIDTH:0]    push_entry;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A request is only taken when a FIFO slot is free, so the eventual
    // push can never overflow.
    assign bus.req_ready = (state == ST_IDLE) && (count < CNT_W'(RESP_DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    assign push       = (state == ST_WAIT) && (bus.call_done || wait_cnt == WAIT_LAST);
    assign push_entry = bus.call_done ? {1'b0, bus.call_result} : {1'b1, {WIDTH{1'b0}}};

    assign bus.resp_valid = (count != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign {bus.resp_timeout, bus.resp_result} = mem[rd_ptr];

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            wait_cnt       <= '0;
            timeout_count  <= '0;
            bus.call_start <= 1'b0;
            bus.call_a     <= '0;
            bus.call_b     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bus.call_a     <= bus.req_a;
                        bus.call_b     <= bus.req_b;
                        bus.call_start <= 1'b1;
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    bus.call_start <= 1'b0;
                    state          <= ST_GUARD;
                end
                ST_GUARD: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (push) begin
                        state <= ST_IDLE;
                        if (!bus.call_done && timeout_count != 8'hFF)
                            timeout_count <= timeout_count + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is cleared on reset so the combinational head reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < RESP_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop)
                rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_start_done_caller.sv
// Directed bench for start_done_caller with a configurable max() callee model.
module tb_start_done_caller;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       busy;
    logic [7:0] timeout_count;

    always #5 clk = ~clk;

    start_done_caller_if #(.WIDTH(W)) bus ();

    start_done_caller #(.WIDTH(W), .TIMEOUT(64), .RESP_DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    // Callee model: result = max(a, b), done lat cycles after start is seen.
    // hold: done never drops on a new start; pulse: done is a single cycle;
    // never: done never rises.
    int           lat;
    bit           hold, pulse, never;
    logic         cal_done, late_done;
    logic [W-1:0] cal_result;
    bit           pend;
    int           cnt;

    function automatic logic [W-1:0] mx(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    assign bus.call_done   = cal_done | late_done;
    assign bus.call_result = cal_result;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cal_done   <= 1'b0;
            cal_result <= '0;
            pend       <= 1'b0;
            cnt        <= 0;
        end else if (bus.call_start) begin
            if (never) begin
                cal_done <= 1'b0;
                pend     <= 1'b0;
            end else if (lat == 0) begin
                cal_done   <= 1'b1;
                cal_result <= mx(bus.call_a, bus.call_b);
                pend       <= 1'b0;
            end else begin
                pend <= 1'b1;
                cnt  <= lat - 1;
                if (!hold) cal_done <= 1'b0;
            end
        end else if (pend) begin
            if (cnt == 0) begin
                cal_done   <= 1'b1;
                cal_result <= mx(bus.call_a, bus.call_b);
                pend       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (pulse) begin
            cal_done <= 1'b0;
        end
    end

    // Monitor: handshakes sampled at the rising edge.
    int           cyc = 0;
    int           starts = 0;
    int           acc_t[$];
    int           pop_t[$];
    logic [W:0]   resp_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.call_start) starts <= starts + 1;
        if (bus.req_valid && bus.req_ready) acc_t.push_back(cyc);
        if (bus.resp_valid && bus.resp_ready) begin
            resp_q.push_back({bus.resp_timeout, bus.resp_result});
            pop_t.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int n0;
        n0 = acc_t.size();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_t.size() > n0) break;
        end
        check(tag, 64'(acc_t.size() > n0), 64'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input int n);
        for (int i = 0; i < 300; i++) begin
            if (resp_q.size() >= n) break;
            @(negedge clk);
        end
        check(tag, 64'(resp_q.size() >= n), 64'd1);
    endtask

    task automatic clear_logs();
        acc_t.delete();
        pop_t.delete();
        resp_q.delete();
    endtask

    initial begin
        int s0;
        bus.req_valid  = 1'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        lat = 0; hold = 0; pulse = 0; never = 0;
        late_done = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy",       64'(busy),             64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid),  64'd0);
        check("rst_call_start", 64'(bus.call_start),  64'd0);
        check("rst_tcount",     64'(timeout_count),   64'd0);
        check("rst_result",     64'(bus.resp_result), 64'd0);
        check("rst_req_ready",  64'(bus.req_ready),   64'd1);
        reset = 1'b0;

        // 1: single call, done two cycles after start
        lat = 2; pulse = 1; bus.resp_ready = 1'b1;
        clear_logs();
        s0 = starts;
        send("t1_acc", 32'd1, 32'd2);
        check("t1_start_hi", 64'(bus.call_start), 64'd1);
        check("t1_call_a",   64'(bus.call_a),     64'd1);
        check("t1_call_b",   64'(bus.call_b),     64'd2);
        check("t1_busy_hi",  64'(busy),           64'd1);
        check("t1_ready_lo", 64'(bus.req_ready),  64'd0);
        wait_resp("t1_wait", 1);
        @(negedge clk);
        check("t1_busy_lo", 64'(busy),        64'd0);
        check("t1_starts",  64'(starts - s0), 64'd1);
        check("t1_resp",    64'(resp_q[0]),   64'({1'b0, 32'd2}));
        check("t1_latency", 64'(pop_t[0] - acc_t[0]), 64'd5);

        // 2: back-to-back with zero-latency level-done callee
        lat = 0; pulse = 0;
        clear_logs();
        send("t2_acc0", 32'd1, 32'd2);
        send("t2_acc1", 32'd7, 32'd4);
        wait_resp("t2_wait", 2);
        check("t2_resp0",   64'(resp_q[0]), 64'({1'b0, 32'd2}));
        check("t2_resp1",   64'(resp_q[1]), 64'({1'b0, 32'd7}));
        check("t2_spacing", 64'(acc_t[1] - acc_t[0]), 64'd4);
        check("t2_latency", 64'(pop_t[0] - acc_t[0]), 64'd4);

        // 3: backpressure with a full FIFO
        bus.resp_ready = 1'b0;
        clear_logs();
        send("t3_acc0", 32'd1, 32'd2);
        send("t3_acc1", 32'd7, 32'd4);
        repeat (6) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_a     = 32'd5;
        bus.req_b     = 32'd6;
        repeat (10) @(negedge clk);
        check("t3_blocked",   64'(acc_t.size()),    64'd2);
        check("t3_ready_lo",  64'(bus.req_ready),   64'd0);
        check("t3_valid",     64'(bus.resp_valid),  64'd1);
        check("t3_head",      64'(bus.resp_result), 64'd2);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        check("t3_pop1", 64'(resp_q.size()), 64'd1);
        for (int i = 0; i < 20; i++) begin
            if (acc_t.size() >= 3) break;
            @(negedge clk);
        end
        check("t3_acc2", 64'(acc_t.size()), 64'd3);
        bus.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        bus.resp_ready = 1'b1;
        wait_resp("t3_wait", 3);
        check("t3_resp0", 64'(resp_q[0]), 64'({1'b0, 32'd2}));
        check("t3_resp1", 64'(resp_q[1]), 64'({1'b0, 32'd7}));
        check("t3_resp2", 64'(resp_q[2]), 64'({1'b0, 32'd6}));

        // 4: done held high from the previous call, result lags one cycle
        hold = 1; lat = 1;
        clear_logs();
        send("t4_acc0", 32'd9, 32'd3);
        wait_resp("t4_wait0", 1);
        send("t4_acc1", 32'd2, 32'd8);
        wait_resp("t4_wait1", 2);
        check("t4_resp0",   64'(resp_q[0]), 64'({1'b0, 32'd9}));
        check("t4_resp1",   64'(resp_q[1]), 64'({1'b0, 32'd8}));
        check("t4_latency", 64'(pop_t[0] - acc_t[0]), 64'd4);

        // 5: callee never answers -> timeout after 64 wait cycles
        hold = 0; never = 1;
        clear_logs();
        send("t5_acc", 32'd5, 32'd5);
        wait_resp("t5_wait", 1);
        @(negedge clk);
        check("t5_resp",    64'(resp_q[0]), 64'({1'b1, 32'd0}));
        check("t5_latency", 64'(pop_t[0] - acc_t[0]), 64'd67);
        check("t5_tcount",  64'(timeout_count), 64'd1);
        never = 0; lat = 0;
        send("t5_acc_next", 32'd3, 32'd4);
        wait_resp("t5_wait_next", 2);
        check("t5_resp_next",   64'(resp_q[1]),     64'({1'b0, 32'd4}));
        check("t5_tcount_hold", 64'(timeout_count), 64'd1);

        // 6: asynchronous reset while waiting
        never = 1;
        clear_logs();
        send("t6_acc", 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        check("t6_busy_wait", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("t6_busy",       64'(busy),            64'd0);
        check("t6_call_start", 64'(bus.call_start),  64'd0);
        check("t6_call_a",     64'(bus.call_a),      64'd0);
        check("t6_call_b",     64'(bus.call_b),      64'd0);
        check("t6_resp_valid", 64'(bus.resp_valid),  64'd0);
        check("t6_tcount",     64'(timeout_count),   64'd0);
        check("t6_req_ready",  64'(bus.req_ready),   64'd1);
        @(negedge clk);
        reset = 1'b0;
        s0 = starts;
        late_done = 1'b1;
        repeat (4) @(negedge clk);
        late_done = 1'b0;
        check("t6_late_valid", 64'(bus.resp_valid), 64'd0);
        check("t6_late_busy",  64'(busy),           64'd0);
        check("t6_no_resp",    64'(resp_q.size()),  64'd0);
        check("t6_no_start",   64'(starts - s0),    64'd0);
        never = 0; lat = 0;
        send("t6_acc_next", 32'd11, 32'd2);
        wait_resp("t6_wait_next", 1);
        check("t6_resp_next", 64'(resp_q[0]), 64'({1'b0, 32'd11}));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
